// File: rtl/lud2x2_ctrl.sv
// Sequenced 2x2 Doolittle LU controller: bit-serial restoring divider for l21,
// one multiply step for u22, saturating fixed-point results with err/sat status.
module lud2x2_ctrl #(
    parameter int unsigned W    = 8,
    parameter int unsigned FRAC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4*W-1:0]   A,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             sat,
    output logic [4*W-1:0]   L,
    output logic [4*W-1:0]   U
);

    localparam int unsigned DW = W + FRAC;
    localparam int unsigned W1 = W + 1;
    localparam int unsigned XW = 2 * W + 1;
    localparam int unsigned CW = $clog2(DW);

    localparam logic [CW-1:0] LAST_CNT  = CW'(DW - 1);
    localparam logic [DW-1:0] Q_POS_LIM = DW'((1 << (W - 1)) - 1);
    localparam logic [DW-1:0] Q_NEG_LIM = DW'(1 << (W - 1));
    localparam logic [W-1:0]  ONE_Q     = W'(1 << FRAC);
    localparam logic [W-1:0]  S_MAX     = W'((1 << (W - 1)) - 1);
    localparam logic [W-1:0]  S_MIN     = W'(1 << (W - 1));
    localparam logic signed [XW-1:0] U_HI = XW'((1 << (W - 1)) - 1);
    localparam logic signed [XW-1:0] U_LO = XW'(-(1 << (W - 1)));

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;

    logic signed [W-1:0]     r_a11;
    logic signed [W-1:0]     r_a12;
    logic signed [W-1:0]     r_a21;
    logic signed [W-1:0]     r_a22;
    logic                    w_cap;

    logic [W-1:0]            r_rem;
    logic [DW-1:0]           r_dvd;
    logic [W:0]              r_dvs;
    logic [DW-1:0]           r_quo;
    logic                    r_neg;
    logic [CW-1:0]           r_cnt;
    logic [W-1:0]            w_rem_nxt;
    logic [DW-1:0]           w_dvd_nxt;
    logic [W:0]              w_dvs_nxt;
    logic [DW-1:0]           w_quo_nxt;
    logic                    w_neg_nxt;
    logic [CW-1:0]           w_cnt_nxt;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_sat;
    logic [4*W-1:0]          r_l;
    logic [4*W-1:0]          r_u;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_err_nxt;
    logic                    w_sat_nxt;
    logic [4*W-1:0]          w_l_nxt;
    logic [4*W-1:0]          w_u_nxt;

    // Operand magnitudes: W+1 bits so that -2^(W-1) has a representable magnitude
    logic [W:0]              w_a11_x;
    logic [W:0]              w_a21_x;
    logic [W:0]              w_dvs_init;
    logic [W:0]              w_abs_a21;
    logic [DW-1:0]           w_dvd_init;

    assign w_a11_x    = {r_a11[W-1], r_a11};
    assign w_a21_x    = {r_a21[W-1], r_a21};
    assign w_dvs_init = r_a11[W-1] ? (~w_a11_x + W1'(1)) : w_a11_x;
    assign w_abs_a21  = r_a21[W-1] ? (~w_a21_x + W1'(1)) : w_a21_x;
    assign w_dvd_init = DW'({w_abs_a21, {FRAC{1'b0}}});

    // One restoring-division step, shared by CHECK (first bit) and DIV (remaining bits)
    logic [W-1:0]            w_step_rem_in;
    logic [DW-1:0]           w_step_dvd_in;
    logic [W:0]              w_step_dvs_in;
    logic [W:0]              w_trial;
    logic [W:0]              w_diff;
    logic                    w_step_q;
    logic [W-1:0]            w_step_rem;
    logic [DW-1:0]           w_step_dvd;

    assign w_step_rem_in = (r_state == S_CHECK) ? '0 : r_rem;
    assign w_step_dvd_in = (r_state == S_CHECK) ? w_dvd_init : r_dvd;
    assign w_step_dvs_in = (r_state == S_CHECK) ? w_dvs_init : r_dvs;
    assign w_trial       = {w_step_rem_in, w_step_dvd_in[DW-1]};
    assign w_diff        = w_trial - w_step_dvs_in;
    assign w_step_q      = (w_trial >= w_step_dvs_in);
    assign w_step_rem    = w_step_q ? W'(w_diff) : W'(w_trial);
    assign w_step_dvd    = {w_step_dvd_in[DW-2:0], 1'b0};

    // Signed, saturated l21 from the unsigned quotient magnitude
    logic [W-1:0]            w_quo_lo;
    logic [W-1:0]            w_l21_raw;
    logic                    w_l21_ovf;
    logic [W-1:0]            w_l21;

    assign w_quo_lo  = r_quo[W-1:0];
    assign w_l21_raw = r_neg ? (~w_quo_lo + W'(1)) : w_quo_lo;
    assign w_l21_ovf = r_neg ? (r_quo > Q_NEG_LIM) : (r_quo > Q_POS_LIM);
    assign w_l21     = w_l21_ovf ? (r_neg ? S_MIN : S_MAX) : w_l21_raw;

    // u22 = a22 - floor(l21*a12 / 2^FRAC), evaluated wide then clipped to W bits
    logic signed [2*W-1:0]   w_l21_x;
    logic signed [2*W-1:0]   w_a12_x;
    logic signed [2*W-1:0]   w_prod;
    logic signed [2*W-1:0]   w_p;
    logic signed [XW-1:0]    w_p_x;
    logic signed [XW-1:0]    w_a22_x;
    logic signed [XW-1:0]    w_u22_full;
    logic                    w_u22_hi;
    logic                    w_u22_lo;
    logic [W-1:0]            w_u22;

    assign w_l21_x    = {{W{w_l21[W-1]}}, w_l21};
    assign w_a12_x    = {{W{r_a12[W-1]}}, r_a12};
    assign w_prod     = w_l21_x * w_a12_x;
    assign w_p        = w_prod >>> FRAC;
    assign w_p_x      = {w_p[2*W-1], w_p};
    assign w_a22_x    = {{(W + 1){r_a22[W-1]}}, r_a22};
    assign w_u22_full = w_a22_x - w_p_x;
    assign w_u22_hi   = (w_u22_full > U_HI);
    assign w_u22_lo   = (w_u22_full < U_LO);
    assign w_u22      = w_u22_hi ? S_MAX : (w_u22_lo ? S_MIN : w_u22_full[W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for every register of the controller
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_rem_nxt   = r_rem;
        w_dvd_nxt   = r_dvd;
        w_dvs_nxt   = r_dvs;
        w_quo_nxt   = r_quo;
        w_neg_nxt   = r_neg;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_sat_nxt   = r_sat;
        w_l_nxt     = r_l;
        w_u_nxt     = r_u;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cap       = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_sat_nxt   = 1'b0;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_a11 == '0) begin
                    w_err_nxt   = 1'b1;
                    w_l_nxt     = '0;
                    w_u_nxt     = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    // The MSB quotient bit is resolved here so total latency stays 2+W+FRAC
                    w_rem_nxt   = w_step_rem;
                    w_dvd_nxt   = w_step_dvd;
                    w_dvs_nxt   = w_dvs_init;
                    w_quo_nxt   = {{(DW - 1){1'b0}}, w_step_q};
                    w_neg_nxt   = r_a11[W-1] ^ r_a21[W-1];
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                w_rem_nxt = w_step_rem;
                w_dvd_nxt = w_step_dvd;
                w_quo_nxt = {r_quo[DW-2:0], w_step_q};
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                w_l_nxt     = {ONE_Q, {W{1'b0}}, w_l21, ONE_Q};
                w_u_nxt     = {r_a11, r_a12, {W{1'b0}}, w_u22};
                w_sat_nxt   = w_l21_ovf | w_u22_hi | w_u22_lo;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a11 <= '0;
            r_a12 <= '0;
            r_a21 <= '0;
            r_a22 <= '0;
        end else if (w_cap) begin
            r_a11 <= A[4*W-1:3*W];
            r_a12 <= A[3*W-1:2*W];
            r_a21 <= A[2*W-1:W];
            r_a22 <= A[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_sat  <= 1'b0;
            r_l    <= '0;
            r_u    <= '0;
        end else begin
            r_rem  <= w_rem_nxt;
            r_dvd  <= w_dvd_nxt;
            r_dvs  <= w_dvs_nxt;
            r_quo  <= w_quo_nxt;
            r_neg  <= w_neg_nxt;
            r_cnt  <= w_cnt_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            r_sat  <= w_sat_nxt;
            r_l    <= w_l_nxt;
            r_u    <= w_u_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign sat  = r_sat;
    assign L    = r_l;
    assign U    = r_u;

endmodule
